line_buffer_ntap: RTL
=====================

# line_buffer_ntap

Parametrised multi-line buffer for the video simulation pipeline. It accepts one pixel per valid cycle and presents that pixel together with the pixels at the same column from up to NUM_LINES previous rows. It is the column source for NxN window/matrix generators (3x3, 5x5, ...). It generalises the fixed two-line, fixed-width shift buffer:

- Line width is a runtime value.
- Tap count is a parameter.
- Storage is addressed RAM, not a shift chain.
- The block is frame-aware: it tracks row fill and masks taps from rows not yet written.

## Interface
Parameters:
- MAX_HDISP, 1920: maximum line width in pixels; sets RAM depth.
- DATA_W, 8: pixel width in bits.
- NUM_LINES, 2: number of previous-row taps (1..8).
- ADDR_W, $clog2(MAX_HDISP): column counter width.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sof  in  1  start-of-frame pulse; qualifies the same-cycle s_valid pixel as frame column 0, row 0.
- hsize  in  ADDR_W+1  active line width; sampled only on sof or reset.
- s_valid  in  1  input pixel qualifier.
- s_data  in  DATA_W  input pixel.
- m_valid  out  1  output qualifier, s_valid delayed 1 cycle.
- m_data  out  DATA_W  current pixel, delayed 1 cycle.
- m_taps  out  NUM_LINES*DATA_W  packed taps; slice k (bits k*DATA_W +: DATA_W) is the pixel k+1 rows above at the same column.
- m_tap_valid  out  NUM_LINES  bit k set when row (current-k-1) exists in this frame.
- m_col  out  ADDR_W  column of m_data.
- m_eol  out  1  m_data is the last column of its row.

## Operation
- Storage: NUM_LINES single-port-behaviour RAMs, each MAX_HDISP x DATA_W, all addressed by column counter col.
- On each s_valid cycle, all RAMs are read at col. Then, in the same cycle:
  - RAM0[col] <= s_data.
  - RAMk[col] <= RAMk-1 read data.
  - Read-before-write semantics are required: the read returns the old contents.
- Registered read data forms m_taps. Slice k is forced to 0 when m_tap_valid[k]=0.
- Width register hs_r:
  - Loaded from hsize on sof and on reset.
  - hsize=0 or hsize>MAX_HDISP loads MAX_HDISP.
  - Changes to hsize between sof pulses are ignored.
- Column counter col:
  - Increments on s_valid.
  - Wraps to 0 when col==hs_r-1 (end of line).
- Fill counter fill (0..NUM_LINES):
  - Increments on each end-of-line pixel and saturates at NUM_LINES.
  - m_tap_valid = thermometer code of fill: bit k = (fill>k).
- sof handling:
  - sof with s_valid: col and fill are treated as 0 for that pixel. The pixel is written at column 0, and its m_tap_valid is all-zero.
  - sof without s_valid: col and fill are cleared, and hs_r is loaded.
- RAM contents are never cleared. Stale data is masked by m_tap_valid only.
- s_valid low: no RAM write, counters hold, m_valid=0. m_data, m_taps, m_col and m_eol hold their last values.

## Timing
- Latency: s_valid/s_data at cycle N produce m_valid/m_data/m_taps/m_col/m_eol/m_tap_valid at cycle N+1. Gaps in s_valid are passed through unchanged.
- Throughput: one pixel per cycle, no backpressure.
- Reset (rst=1 at an edge):
  - All outputs 0.
  - col=0, fill=0, hs_r loaded from hsize per the clamp rule.
- Reset mid-line: RAMs keep their data, but fill=0 masks it. The first valid pixel after reset is column 0, row 0.
- End of line and sof in the same cycle: sof wins. col=0, fill=0, and no fill increment.
- Row count is unbounded within a frame. fill saturating is the normal steady state.

## Test plan
- Parameters DATA_W=8, NUM_LINES=2, hsize=4; sof plus 12 contiguous pixels 0..11 -> outputs:
  - Row 0: taps 0, m_tap_valid=00.
  - Row 1 (pixels 4..7): tap0=0..3, m_tap_valid=01.
  - Row 2 (pixels 8..11): tap0=4..7, tap1=0..3, m_tap_valid=11.
  - m_eol on pixels 3, 7, 11; all outputs 1 cycle after input.
- Same stream with s_valid low on alternate cycles -> identical output values; m_valid toggles with 1-cycle lag; outputs hold during gaps.
- hsize=4 frame, then sof with hsize=3 mid-row -> new-frame pixel at m_col=0, m_tap_valid=00; wrap now after column 2; a hsize change without sof is ignored.
- hsize=0 and hsize=MAX_HDISP+5 at sof -> m_eol asserted at column MAX_HDISP-1.
- Assert rst after 6 pixels of a hsize=4 frame, then resume -> all outputs 0 during reset; next pixel has m_col=0, m_tap_valid=00, and masked taps are 0 despite stale RAM.
- NUM_LINES=4, hsize=3, 18 pixels -> m_tap_valid steps 0000, 0001, 0011, 0111, 1111, 1111 per row; tap3 on the last row equals row 1 data.

Source files
------------

// File: rtl/line_buffer_ntap.sv
// rtl/line_buffer_ntap.sv - frame-aware multi-line buffer presenting a pixel plus NUM_LINES same-column taps
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   sof               start of frame; marks the same-cycle pixel as row 0, column 0
//   hsize             active line width, captured on sof or reset (0 or >MAX_HDISP -> MAX_HDISP)
//   s_valid, s_data   input pixel stream, one pixel per valid cycle
//   m_valid, m_data   current pixel, one cycle later
//   m_taps            slice k = pixel k+1 rows above at the same column (0 when masked)
//   m_tap_valid       bit k set when that row exists in the current frame
//   m_col, m_eol      column of m_data and end-of-line flag
module line_buffer_ntap #(
    parameter int MAX_HDISP = 1920,
    parameter int DATA_W    = 8,
    parameter int NUM_LINES = 2,
    parameter int ADDR_W    = $clog2(MAX_HDISP)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sof,
    input  logic [ADDR_W:0]               hsize,
    input  logic                          s_valid,
    input  logic [DATA_W-1:0]             s_data,
    output logic                          m_valid,
    output logic [DATA_W-1:0]             m_data,
    output logic [NUM_LINES*DATA_W-1:0]   m_taps,
    output logic [NUM_LINES-1:0]          m_tap_valid,
    output logic [ADDR_W-1:0]             m_col,
    output logic                          m_eol
);

    localparam int              FILL_W = $clog2(NUM_LINES + 1);
    localparam logic [ADDR_W:0] HS_MAX = (ADDR_W + 1)'(MAX_HDISP);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NUM_LINES);

    logic [ADDR_W:0]       hs_q, hs_load, hs_eff;
    logic [ADDR_W-1:0]     col_q, col_d, col_eff;
    logic [FILL_W-1:0]     fill_q, fill_d, fill_eff;
    logic                  eol;
    logic [NUM_LINES-1:0]  tv_eff;

    logic                  m_valid_q;
    logic [DATA_W-1:0]     m_data_q;
    logic [NUM_LINES-1:0]  tv_q;
    logic [ADDR_W-1:0]     m_col_q;
    logic                  m_eol_q;

    logic [DATA_W-1:0]     mem [NUM_LINES][MAX_HDISP];
    logic [DATA_W-1:0]     rd_q [NUM_LINES];

    // A sof pixel starts a fresh frame: it sees column 0, no filled rows and
    // the newly presented width, even though the registers update only after it.
    always_comb begin
        hs_load  = (hsize == '0 || hsize > HS_MAX) ? HS_MAX : hsize;
        hs_eff   = sof ? hs_load : hs_q;
        col_eff  = sof ? '0 : col_q;
        fill_eff = sof ? '0 : fill_q;
        eol      = ({1'b0, col_eff} == hs_eff - 1'b1);
        for (int k = 0; k < NUM_LINES; k++) begin
            tv_eff[k] = (fill_eff > FILL_W'(k));
        end
    end

    always_comb begin
        col_d  = col_eff;
        fill_d = fill_eff;
        if (s_valid) begin
            col_d = eol ? '0 : col_eff + 1'b1;
            // The row that ends on a sof pixel does not count toward fill.
            if (eol && !sof && fill_eff != FILL_MAX) begin
                fill_d = fill_eff + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q      <= hs_load;
            col_q     <= '0;
            fill_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            tv_q      <= '0;
            m_col_q   <= '0;
            m_eol_q   <= 1'b0;
        end else begin
            if (sof) begin
                hs_q <= hs_load;
            end
            col_q     <= col_d;
            fill_q    <= fill_d;
            m_valid_q <= s_valid;
            if (s_valid) begin
                m_data_q <= s_data;
                tv_q     <= tv_eff;
                m_col_q  <= col_eff;
                m_eol_q  <= eol;
            end
        end
    end

    // Line RAMs are never reset; stale rows are hidden by the tap mask.
    // Non-blocking reads give the pre-write contents, so each RAM passes its
    // old column value down to the next-older line in the same cycle.
    always_ff @(posedge clk) begin
        if (s_valid && !rst) begin
            rd_q[0]         <= mem[0][col_eff];
            mem[0][col_eff] <= s_data;
            for (int k = 1; k < NUM_LINES; k++) begin
                rd_q[k]         <= mem[k][col_eff];
                mem[k][col_eff] <= mem[k-1][col_eff];
            end
        end
    end

    always_comb begin
        m_taps = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            m_taps[k*DATA_W +: DATA_W] = tv_q[k] ? rd_q[k] : '0;
        end
    end

    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_tap_valid = tv_q;
    assign m_col       = m_col_q;
    assign m_eol       = m_eol_q;

endmodule
